// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the hex -> active-low segment decoder.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} patterns, entry [n] is hex digit n
  localparam logic [15:0][SEG_W-1:0] SEG_HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_W-1:0] seg7_decode(input logic [3:0] nibble);
    return ~SEG_HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability debouncer for one active-low button.
// The first level accepted after reset never produces a fall pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic level,
  output logic fall_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [2:0]       r_warm;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_init;
  logic             r_fall;
  logic             w_same;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= in_n;
      r_sync2 <= r_sync1;
    end
  end

  // Samples taken before the synchronizer refills after reset are not trusted
  assign w_same    = r_warm[2] && (r_sync2 == r_prev);
  assign w_cnt_nxt = !w_same ? '0 : ((r_cnt == CNT_LAST) ? r_cnt : r_cnt + CNT_W'(1));
  assign w_stable  = r_warm[1] && (w_cnt_nxt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm  <= '0;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_init  <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_warm <= {r_warm[1:0], 1'b1};
      r_prev <= r_sync2;
      r_cnt  <= w_cnt_nxt;
      r_fall <= 1'b0;
      if (w_stable) begin
        r_init <= 1'b0;
        if (r_sync2 != r_level) begin
          r_level <= r_sync2;
          r_fall  <= !r_init && !r_sync2;
        end
      end
    end
  end

  assign level      = r_level;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/seg7_hex_counter_display.sv
// Debounced up/down hex counter on NUM_DIGITS 7-segment digits plus a direct switch digit.
// Define SEG7_LZB_EN to blank leading zero digits of the counter display.
module seg7_hex_counter_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_n,
  input  logic                        clr_n,
  input  logic                        dir,
  input  logic [3:0]                  hex_in,
  output logic [SEG_W-1:0]            seg_sw,
  output logic [SEG_W*NUM_DIGITS-1:0] seg_cnt,
  output logic [4*NUM_DIGITS-1:0]     count,
  output logic                        wrap
);

  localparam int unsigned CNT_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_btn_lvl;
  logic             w_btn_fall;
  logic             w_clr_lvl;
  logic             w_clr_fall;
  logic             w_press;
  logic             w_clr;
  logic [CNT_W-1:0] r_count;
  logic             r_wrap;
  logic [SEG_W-1:0] r_seg_sw;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk        (clk),
    .rst        (rst),
    .in_n       (btn_n),
    .level      (w_btn_lvl),
    .fall_pulse (w_btn_fall)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk        (clk),
    .rst        (rst),
    .in_n       (clr_n),
    .level      (w_clr_lvl),
    .fall_pulse (w_clr_fall)
  );

  // A fall pulse always coincides with a low accepted level
  assign w_press = w_btn_fall && !w_btn_lvl;
  assign w_clr   = !w_clr_lvl || w_clr_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_clr) begin
        r_count <= '0;
      end else if (w_press) begin
        if (dir) begin
          r_count <= r_count - CNT_W'(1);
          r_wrap  <= (r_count == '0);
        end else begin
          r_count <= r_count + CNT_W'(1);
          r_wrap  <= (r_count == CNT_MAX);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0]       w_nib;
    logic             w_blank;
    logic [SEG_W-1:0] r_seg;

    assign w_nib = r_count[4*gi +: 4];
`ifdef SEG7_LZB_EN
    localparam logic [SEG_W-1:0] SEG_RST = (gi == 0) ? seg7_decode(4'h0) : SEG_BLANK;
    assign w_blank = (gi != 0) && ((r_count >> (4*gi)) == '0);
`else
    localparam logic [SEG_W-1:0] SEG_RST = seg7_decode(4'h0);
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_seg <= SEG_RST;
      else     r_seg <= w_blank ? SEG_BLANK : seg7_decode(w_nib);
    end

    assign seg_cnt[SEG_W*gi +: SEG_W] = r_seg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_seg_sw <= SEG_BLANK;
    else     r_seg_sw <= seg7_decode(hex_in);
  end

  assign seg_sw = r_seg_sw;
  assign count  = r_count;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_seg7_hex_counter_display.sv
// Bench for seg7_hex_counter_display: decode table, directed corner sequences, random model run.
module tb_seg7_hex_counter_display;

  localparam int ND  = 2;
  localparam int DC  = 4;
  localparam int MOD = 256;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        btn_n  = 1'b1;
  logic        clr_n  = 1'b1;
  logic        dir    = 1'b0;
  logic [3:0]  hex_in = 4'h0;
  logic [6:0]  seg_sw;
  logic [13:0] seg_cnt;
  logic [7:0]  count;
  logic        wrap;

  always #5 clk = ~clk;

  seg7_hex_counter_display #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DC)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (btn_n),
    .clr_n   (clr_n),
    .dir     (dir),
    .hex_in  (hex_in),
    .seg_sw  (seg_sw),
    .seg_cnt (seg_cnt),
    .count   (count),
    .wrap    (wrap)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference segment art, active-high, indexed by hex value
  localparam logic [6:0] SEG_HI [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] ref_seg(input int n);
    return ~SEG_HI[n];
  endfunction

  function automatic logic [13:0] ref_digits(input int v);
    logic [13:0] r;
    logic [6:0]  s;
    int          p;
    r = '0;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      s = ref_seg((v / p) % 16);
`ifdef SEG7_LZB_EN
      if (i > 0 && (v / p) == 0) s = 7'h7F;
`endif
      r[7*i +: 7] = s;
      p = p * 16;
    end
    return r;
  endfunction

  // True when the last DC synchronized samples exist and agree; v is that value
  function automatic bit win_stable(input bit q[$], output bit v);
    v = 1'b1;
    if (q.size() < DC + 2) return 1'b0;
    v = q[0];
    for (int i = 1; i < DC; i++) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural model, stepped on each rising edge from the bench's own inputs
  int         m_count;
  bit         m_wrap;
  logic [13:0] m_seg_cnt;
  logic [6:0] m_seg_sw;
  bit         m_bl, m_bi, m_bp, m_cl, m_ci;
  bit         qb[$];
  bit         qc[$];
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    bit v;
    if (rst) begin
      m_count = 0; m_wrap = 0;
      m_seg_cnt = ref_digits(0); m_seg_sw = 7'h7F;
      m_bl = 1; m_bi = 1; m_bp = 0; m_cl = 1; m_ci = 1;
      qb.delete(); qc.delete();
    end else begin
      m_seg_cnt = ref_digits(m_count);
      m_seg_sw  = ref_seg(int'(hex_in));
      m_wrap = 0;
      if (!m_cl) m_count = 0;
      else if (m_bp) begin
        if (!dir) begin m_wrap = (m_count == MOD - 1); m_count = (m_count + 1) % MOD; end
        else      begin m_wrap = (m_count == 0);       m_count = (m_count + MOD - 1) % MOD; end
      end
      qb.push_back(btn_n); if (qb.size() > DC + 2) void'(qb.pop_front());
      qc.push_back(clr_n); if (qc.size() > DC + 2) void'(qc.pop_front());
      m_bp = 0;
      if (win_stable(qb, v)) begin
        if (v != m_bl) begin m_bl = v; m_bp = !m_bi && !v; end
        m_bi = 0;
      end
      if (win_stable(qc, v)) begin
        m_cl = v; m_ci = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_count",   32'(count),   32'(m_count));
      check("model_wrap",    32'(wrap),    32'(m_wrap));
      check("model_seg_cnt", 32'(seg_cnt), 32'(m_seg_cnt));
      check("model_seg_sw",  32'(seg_sw),  32'(m_seg_sw));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_w(input bit d, output int wraps);
    wraps = 0;
    dir = d;
    btn_n = 1'b0;
    for (int i = 0; i < DC + 6; i++) begin tick(1); if (wrap) wraps++; end
    btn_n = 1'b1;
    for (int i = 0; i < DC + 6; i++) begin tick(1); if (wrap) wraps++; end
  endtask

  task automatic check_reset_vals(input string tag);
    logic [13:0] exp_cnt;
`ifdef SEG7_LZB_EN
    exp_cnt = {7'h7F, 7'b1000000};
`else
    exp_cnt = {7'b1000000, 7'b1000000};
`endif
    check({tag, "_count"},   32'(count),   32'h0);
    check({tag, "_wrap"},    32'(wrap),    32'h0);
    check({tag, "_seg_cnt"}, 32'(seg_cnt), 32'(exp_cnt));
    check({tag, "_seg_sw"},  32'(seg_sw),  32'h7F);
  endtask

  typedef struct {
    logic [3:0] hex;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t vecs [16];

  initial begin
    int w;
    vecs = '{
      '{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
      '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
      '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
      '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}
    };

    tick(2);
    check_reset_vals("por");
    rst = 1'b0;
    chk_en = 1'b1;

    // Direct digit decode, one clock after hex_in
    for (int i = 0; i < 16; i++) begin
      hex_in = vecs[i].hex;
      tick(1);
      check("decode_sw", 32'(seg_sw), 32'(vecs[i].seg));
    end

    // Bouncing button counts exactly once
    repeat (5) begin btn_n = 1'b0; tick(2); btn_n = 1'b1; tick(2); end
    btn_n = 1'b0; tick(10);
    check("bounce_press", 32'(count), 32'h01);
    btn_n = 1'b1; tick(10);
    repeat (5) begin btn_n = 1'b0; tick(2); btn_n = 1'b1; tick(2); end
    tick(10);
    check("bounce_release", 32'(count), 32'h01);

    // Wrap in both directions
    press_w(1'b1, w);
    check("down_to_zero", 32'(count), 32'h00);
    check("down_to_zero_wrap", 32'(w), 32'd0);
    press_w(1'b1, w);
    check("down_wrap_cnt", 32'(count), 32'hFF);
    check("down_wrap_pulse", 32'(w), 32'd1);
    press_w(1'b0, w);
    check("up_wrap_cnt", 32'(count), 32'h00);
    check("up_wrap_pulse", 32'(w), 32'd1);
    press_w(1'b1, w);
    check("down_wrap_cnt2", 32'(count), 32'hFF);
    check("down_wrap_pulse2", 32'(w), 32'd1);
    press_w(1'b0, w);
    check("up_wrap_cnt2", 32'(count), 32'h00);

    // dir flipped after the press is taken has no effect
    dir = 1'b0; btn_n = 1'b0; tick(DC + 4);
    dir = 1'b1; tick(6);
    btn_n = 1'b1; tick(DC + 6);
    check("dir_mid_hold", 32'(count), 32'h01);
    press_w(1'b0, w);
    check("pre_clear", 32'(count), 32'h02);

    // Clear and press accepted together
    w = 0;
    btn_n = 1'b0; clr_n = 1'b0;
    for (int i = 0; i < DC + 8; i++) begin tick(1); if (wrap) w++; end
    check("clr_vs_press", 32'(count), 32'h00);
    check("clr_no_wrap", 32'(w), 32'd0);
    btn_n = 1'b1; tick(DC + 6);
    dir = 1'b0; btn_n = 1'b0; tick(DC + 6); btn_n = 1'b1; tick(DC + 6);
    check("clr_held", 32'(count), 32'h00);
    clr_n = 1'b1; tick(DC + 6);
    check("clr_released", 32'(count), 32'h00);

    // Leading-zero display of 0x05
    repeat (5) press_w(1'b0, w);
    check("lzb_count", 32'(count), 32'h05);
`ifdef SEG7_LZB_EN
    check("lzb_digit1", 32'(seg_cnt[13:7]), 32'h7F);
`else
    check("lzb_digit1", 32'(seg_cnt[13:7]), 32'h40);
`endif
    check("lzb_digit0", 32'(seg_cnt[6:0]), 32'h12);

    // Reset mid-debounce with the button held through reset release
    btn_n = 1'b0; tick(3);
    #2 rst = 1'b1;
    #1 check_reset_vals("mid_rst");
    tick(2);
    #2 rst = 1'b0;
    tick(DC + 8);
    check("held_thru_rst", 32'(count), 32'h00);
    btn_n = 1'b1; tick(DC + 6);
    press_w(1'b0, w);
    check("after_rst_press", 32'(count), 32'h01);

    // Random bounce, clear, direction and switch activity against the model
    for (int it = 0; it < 300; it++) begin
      int n;
      hex_in = 4'($urandom_range(0, 15));
      dir    = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 6);
      repeat (n) begin btn_n = 1'($urandom_range(0, 1)); tick(1); end
      btn_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) clr_n = ~clr_n;
      tick($urandom_range(1, 10));
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        tick(2);
        #2 rst = 1'b0;
      end
    end
    btn_n = 1'b1; clr_n = 1'b1;
    tick(DC + 8);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
